// File: rtl/mio_responder.sv
// Instruction memory with loader plus a handshaked data responder for the SCPU MIO port.
// Optional macro MIO_WAIT_EN inserts WAIT_CYCLES wait states per data access.
module mio_responder #(
  parameter int IMEM_DEPTH  = 256,
  parameter int DMEM_DEPTH  = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_out,
  output logic [31:0] inst_in,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        bus_err
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_DEPTH);

`ifdef MIO_WAIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  logic [3:0] cnt_reg, cnt_next;
`else
  typedef enum logic [1:0] {IDLE, ACK} state_t;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg;
  logic        wr_reg;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_wr, acc_err, commit;
  logic        unused_bits;

  assign unused_bits = ^{PC_out[1:0], prog_addr[1:0]};

  // Loader has no reset so a program can be written while the core is held in reset.
  always_ff @(posedge clk) begin
    if (prog_we && (prog_addr < IMEM_BYTES))
      imem[prog_addr[IAW+1:2]] <= prog_data;
  end

  assign inst_in = (PC_out < IMEM_BYTES) ? imem[PC_out[IAW+1:2]] : 32'h0;

  // In IDLE the access is taken straight from the bus so a zero-wait commit needs no latch.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    acc_addr   = addr_reg;
    acc_wdata  = wdata_reg;
    acc_wr     = wr_reg;
`ifdef MIO_WAIT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (CPU_MIO) begin
          acc_addr  = Addr_out;
          acc_wdata = Data_out;
          acc_wr    = mem_w;
`ifdef MIO_WAIT_EN
          cnt_next  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_next = ACK;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
          end
`else
          state_next = ACK;
          commit     = 1'b1;
`endif
        end
      end
`ifdef MIO_WAIT_EN
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = ACK;
          commit     = 1'b1;
        end
      end
`endif
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= DMEM_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      wr_reg    <= 1'b0;
      MIO_ready <= 1'b0;
      Data_in   <= 32'h0;
      bus_err   <= 1'b0;
`ifdef MIO_WAIT_EN
      cnt_reg   <= 4'd0;
`endif
    end else begin
      state_reg <= state_next;
      MIO_ready <= commit;
`ifdef MIO_WAIT_EN
      cnt_reg   <= cnt_next;
`endif
      if (state_reg == IDLE && CPU_MIO) begin
        addr_reg  <= Addr_out;
        wdata_reg <= Data_out;
        wr_reg    <= mem_w;
      end
      if (commit) begin
        if (acc_err) begin
          Data_in <= 32'h0;
          bus_err <= 1'b1;
        end else if (!acc_wr) begin
          Data_in <= dmem[acc_addr[DAW+1:2]];
        end
      end
    end
  end

  // Gated by reset so an access interrupted by reset never lands in memory.
  always_ff @(posedge clk) begin
    if (reset && commit && acc_wr && !acc_err)
      dmem[acc_addr[DAW+1:2]] <= acc_wdata;
  end

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: fetch/load, table-driven data accesses, hold and reset corners.
`timescale 1ns/1ps
module tb_mio_responder;

  localparam int WAIT_CYCLES = 2;
`ifdef MIO_WAIT_EN
  localparam int W_EFF = WAIT_CYCLES;
`else
  localparam int W_EFF = 0;
`endif
  localparam int PERIOD = W_EFF + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_out = 32'h0;
  logic [31:0] inst_in;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] Addr_out = 32'h0;
  logic [31:0] Data_out = 32'h0;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = 32'h0;
  logic [31:0] prog_data = 32'h0;
  logic        bus_err;

  always #5 clk = ~clk;

  mio_responder #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PC_out   (PC_out),
    .inst_in  (inst_in),
    .CPU_MIO  (CPU_MIO),
    .mem_w    (mem_w),
    .Addr_out (Addr_out),
    .Data_out (Data_out),
    .Data_in  (Data_in),
    .MIO_ready(MIO_ready),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .bus_err  (bus_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input vec_t v, input string name);
    vec_t e;
    int   n;
    bit   seen;
    CPU_MIO  = 1'b1;
    mem_w    = v.wr;
    Addr_out = v.addr;
    Data_out = v.wdata;
    sb_q.push_back(v);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick;
      n++;
      if (MIO_ready) begin
        seen = 1'b1;
        e = sb_q.pop_front();
        $display("access %s wr=%0b addr=%h data_in=%h bus_err=%0b cycles=%0d",
                 name, e.wr, e.addr, Data_in, bus_err, n);
        chk({name, " latency"}, 32'(n), 32'(W_EFF + 1));
        if (e.chk_data) chk({name, " data"}, Data_in, e.exp_data);
        chk({name, " bus_err"}, {31'h0, bus_err}, {31'h0, e.exp_err});
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no MIO_ready expected one within 40 cycles", name);
      void'(sb_q.pop_front());
    end
    CPU_MIO = 1'b0;
    tick;
    chk({name, " single pulse"}, {31'h0, MIO_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    int   pulses, n, last;
    logic [31:0] exp_rd;

    //        wr    addr          wdata          chk   exp_data       err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0013, 32'h7777_7777, 1'b1, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0400, 32'h9999_9999, 1'b1, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0402, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 1'b1};

    // Reset values, then program load while reset is held.
    tick;
    chk("reset MIO_ready", {31'h0, MIO_ready}, 32'h0);
    chk("reset Data_in", Data_in, 32'h0);
    chk("reset bus_err", {31'h0, bus_err}, 32'h0);
    prog_we = 1'b1;
    prog_addr = 32'h0;   prog_data = 32'h2011_0001; tick;
    prog_addr = 32'h4;   prog_data = 32'h1232_0006; tick;
    prog_addr = 32'h3FC; prog_data = 32'hABCD_0123; tick;
    prog_addr = 32'h400; prog_data = 32'hFFFF_FFFF; tick;
    prog_we = 1'b0;
    reset = 1'b1;
    tick;

    PC_out = 32'h4;    #1; chk("fetch 0x4", inst_in, 32'h1232_0006);
    PC_out = 32'h6;    #1; chk("fetch 0x6 low bits", inst_in, 32'h1232_0006);
    PC_out = 32'h0;    #1; chk("fetch 0x0 after dropped load", inst_in, 32'h2011_0001);
    PC_out = 32'h3FC;  #1; chk("fetch last word", inst_in, 32'hABCD_0123);
    PC_out = 32'h400;  #1; chk("fetch 0x400 nop", inst_in, 32'h0);
    PC_out = 32'h1000; #1; chk("fetch 0x1000 nop", inst_in, 32'h0);
    $display("fetch checks done");

    PC_out = 32'h8;
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'h1357_9BDF;
    tick;
    prog_we = 1'b0;
    chk("live load fetch", inst_in, 32'h1357_9BDF);

    for (int i = 0; i < 8; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back requests with CPU_MIO held high, alternating addresses.
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h0;
    pulses = 0; n = 0; last = 0;
    while (pulses < 5 && n < 100) begin
      tick;
      n++;
      if (MIO_ready) begin
        exp_rd = (Addr_out == 32'h0) ? 32'h1111_1111 : 32'h2222_2222;
        $display("hold pulse %0d cycle=%0d addr=%h data_in=%h", pulses, n, Addr_out, Data_in);
        if (pulses == 0) chk("hold first latency", 32'(n), 32'(W_EFF + 1));
        else             chk("hold spacing", 32'(n - last), 32'(PERIOD));
        chk("hold data", Data_in, exp_rd);
        last = n;
        pulses++;
        Addr_out = (Addr_out == 32'h0) ? 32'h4 : 32'h0;
      end
    end
    chk("hold pulse count", 32'(pulses), 32'd5);
    CPU_MIO = 1'b0;
    tick;

    for (int i = 8; i < 13; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Reset one cycle after a write request; uncommitted write is lost.
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h20; Data_out = 32'h5A5A_5A5A;
    tick;
    tick;
    CPU_MIO = 1'b0;
    reset = 1'b0;
    #1;
    $display("reset mid-access: MIO_ready=%0b bus_err=%0b", MIO_ready, bus_err);
    chk("abort MIO_ready", {31'h0, MIO_ready}, 32'h0);
    chk("abort bus_err", {31'h0, bus_err}, 32'h0);
    chk("abort Data_in", Data_in, 32'h0);
    tick;
    tick;
    reset = 1'b1;
    tick;
    hv = '{1'b0, 32'h20, 32'h0, 1'b1, (W_EFF > 1) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A, 1'b0};
    run_access(hv, "reread 0x20");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
# mio_responder

Memory/IO responder for the `SCPU` core's instruction and MIO data ports. It returns instructions on `inst_in` for every `PC_out`, and serves CPU data reads and writes through the `CPU_MIO`/`MIO_ready` handshake with a configurable wait-state FSM. It sits beside the CPU in the SoC and in CPU test benches, replacing hand-driven `inst_in`/`Data_in` stimulus.

## Interface
- `IMEM_DEPTH`, 256, instruction words (power of 2)
- `DMEM_DEPTH`, 256, data words (power of 2)
- `WAIT_CYCLES`, 2, extra wait states per data access (0..15; used only with `MIO_WAIT_EN`)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `PC_out`  in  32  CPU fetch byte address
- `inst_in`  out  32  instruction at `PC_out`
- `CPU_MIO`  in  1  CPU data request
- `mem_w`  in  1  1 = write, 0 = read; valid with `CPU_MIO`
- `Addr_out`  in  32  data byte address
- `Data_out`  in  32  write data
- `Data_in`  out  32  read data, valid while `MIO_ready`=1
- `MIO_ready`  out  1  one-cycle completion strobe
- `prog_we`  in  1  instruction-memory load strobe
- `prog_addr`  in  32  load byte address
- `prog_data`  in  32  load word
- `bus_err`  out  1  sticky error flag

## Operation
- Fetch: `inst_in` = imem[`PC_out[k+1:2]`], where k = log2(`IMEM_DEPTH`). It is a combinational read. If `PC_out` ≥ 4*`IMEM_DEPTH`, `inst_in` = 0 (nop). `PC_out[1:0]` is ignored.
- Load: when `prog_we`=1 at a rising edge, imem[`prog_addr[k+1:2]`] ← `prog_data`. Loads are accepted while `reset`=0, so the bench can load during reset. Out-of-range loads are dropped. The CPU can never write imem.
- Data FSM states: IDLE, WAIT, ACK.
  - IDLE: on an edge with `CPU_MIO`=1, latch addr, wdata and `mem_w`. Load the wait counter with `WAIT_CYCLES`. Go to WAIT if the counter is nonzero, otherwise go to ACK.
  - WAIT: decrement the counter each edge. When it reaches 0, go to ACK.
  - On the edge entering ACK: a write commits to dmem; a read registers dmem[word] into `Data_in`.
  - ACK: `MIO_ready`=1 for exactly this cycle. The next edge always returns to IDLE, even if `CPU_MIO` is still 1, so one idle cycle is mandatory between accesses.
- The CPU holds `Addr_out`, `Data_out` and `mem_w` stable from request until it samples `MIO_ready`=1. Only the values latched in IDLE are used; changes during WAIT are ignored.
- Error: the access is an error if the address is misaligned (`Addr_out[1:0]`≠0) or out of range (≥ 4*`DMEM_DEPTH`). An error access still completes with normal timing, but the write is dropped, `Data_in` = 0, and `bus_err` is set. `bus_err` clears only on reset.
- Memory arrays are not cleared by reset.

## Timing
- Reset values: `MIO_ready`=0, `Data_in`=0, `bus_err`=0, FSM=IDLE, counter=0. `inst_in` follows imem contents.
- Reset asserted mid-access aborts it. A write not yet committed (ACK not yet entered) is lost.
- Data latency: `MIO_ready` rises `WAIT_CYCLES`+1 cycles after the request-sampling edge.
- Minimum request-to-request spacing is `WAIT_CYCLES`+2 cycles.
- Read-after-write to the same address returns the new data.
- Fetch has zero latency and is independent of the data FSM. A `prog_we` write to an address being fetched makes `inst_in` show the new word after that edge.

## Configuration
- `MIO_WAIT_EN` defined: wait states are inserted as above.
- `MIO_WAIT_EN` undefined: the WAIT state and counter are compiled out and `WAIT_CYCLES` is ignored. IDLE goes directly to ACK, so `MIO_ready` comes 1 cycle after the request edge and spacing is 2 cycles.

## Test plan
- Reset with `reset`=0, load `prog_addr`=0 ← 32'h20110001 and 4 ← 32'h12320006, then release reset. Set `PC_out`=4 → `inst_in`=32'h12320006. Set `PC_out`=32'h1000 → `inst_in`=0.
- With `WAIT_CYCLES`=2 and `MIO_WAIT_EN` defined: write 32'hDEADBEEF to 32'h10 → `MIO_ready` is high exactly 3 cycles after the request edge, for one cycle. Then read 32'h10 → `Data_in`=32'hDEADBEEF while `MIO_ready`=1.
- Hold `CPU_MIO`=1 continuously with reads of 32'h0 and 32'h4 → `MIO_ready` pulses every 4 cycles, never on two consecutive cycles.
- Write to 32'h13 (misaligned), then to 32'h400 (out of range) → both complete, `bus_err`=1, `Data_in`=0. A reread of 32'h10 still returns 32'hDEADBEEF.
- Assert reset one cycle after a write request to 32'h20 → `MIO_ready`=0 and `bus_err`=0 immediately. A later read of 32'h20 returns the old contents.
- With `MIO_WAIT_EN` undefined: read 32'h10 → `MIO_ready` is high 1 cycle after the request edge.
